// File: rtl/mem_access_unit_if.sv
// Data-memory port bundle: word-addressed req/ack access with byte enables.
// Latency: none (signal grouping only).
// Backpressure: the master holds req and its fields stable until the slave returns ack.
interface mem_access_unit_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  be;
   logic [31:0] rdata;
   logic        ack;

   modport master (
      output req, we, addr, wdata, be,
      input  rdata, ack
   );

   modport slave (
      input  req, we, addr, wdata, be,
      output rdata, ack
   );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: issues req/ack data-memory accesses and returns the extracted load value.
// Latency: access seen in IDLE, request held in WAIT until ack, one DONE cycle; minimum stall is 2 cycles.
// Backpressure: stall_o freezes the pipeline until the memory acks (or the watchdog fires when MEM_TIMEOUT_EN is defined).
module mem_access_unit #(
   parameter int TIMEOUT_CYC = 64
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              memRead_i,
   input  logic              memWrite_i,
   input  logic [2:0]        funct3_i,
   input  logic [31:0]       addr_i,
   input  logic [31:0]       wrData_i,
   mem_access_unit_if.master mem,
   output logic              stall_o,
   output logic [31:0]       memData_o,
   output logic              misalign_o,
   output logic              err_o
);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t      state;
   logic [1:0]  laneQ;
   logic [1:0]  sizeQ;
   logic        unsQ;
   logic        loadQ;

   logic        access;
   logic        misaligned;
   logic [3:0]  beNext;
   logic [31:0] wdataNext;

   if (TIMEOUT_CYC < 1) begin : gBadTimeout
      $error("TIMEOUT_CYC must be at least 1");
   end

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] waitCnt;
`endif

   // Pick the addressed byte/halfword out of the read word and extend it.
   function automatic logic [31:0] extractLoad(input logic [31:0] word, input logic [1:0] lane,
                                               input logic [1:0] size, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      case (lane)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = lane[1] ? word[31:16] : word[15:0];
      case (size)
         2'b00:   return uns ? {24'b0, b} : {{24{b[7]}}, b};
         2'b01:   return uns ? {16'b0, h} : {{16{h[15]}}, h};
         default: return word;
      endcase
   endfunction

   // Decode the incoming access: alignment check, byte enables and lane-replicated store data.
   always_comb begin
      access     = memRead_i | memWrite_i;
      misaligned = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                   (funct3_i[1] && (addr_i[1:0] != 2'b00));
      beNext     = 4'b1111;
      wdataNext  = wrData_i;
      if (memWrite_i) begin
         case (funct3_i[1:0])
            2'b00: begin
               beNext    = 4'b0001 << addr_i[1:0];
               wdataNext = {4{wrData_i[7:0]}};
            end
            2'b01: begin
               beNext    = addr_i[1] ? 4'b1100 : 4'b0011;
               wdataNext = {2{wrData_i[15:0]}};
            end
            default: ;
         endcase
      end
   end

   // Stall while an aligned access is being launched or is outstanding; DONE releases the pipeline.
   assign stall_o    = !rst_i && (((state == IDLE) && access && !misaligned) || (state == WAIT));
   assign misalign_o = (state == IDLE) && access && misaligned;

   // Access sequencer: launch in IDLE, hold the request through WAIT, one release cycle in DONE.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= IDLE;
         mem.req   <= 1'b0;
         mem.we    <= 1'b0;
         mem.addr  <= 32'b0;
         mem.wdata <= 32'b0;
         mem.be    <= 4'b0;
         memData_o <= 32'b0;
         laneQ     <= 2'b0;
         sizeQ     <= 2'b0;
         unsQ      <= 1'b0;
         loadQ     <= 1'b0;
`ifdef MEM_TIMEOUT_EN
         waitCnt   <= '0;
         err_o     <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (access) begin
                  if (misaligned) begin
                     // Faulting load still writes back a defined value; no memory traffic.
                     if (!memWrite_i) memData_o <= 32'b0;
                  end else begin
                     mem.req   <= 1'b1;
                     mem.we    <= memWrite_i;
                     mem.addr  <= {addr_i[31:2], 2'b00};
                     mem.wdata <= wdataNext;
                     mem.be    <= beNext;
                     laneQ     <= addr_i[1:0];
                     sizeQ     <= funct3_i[1:0];
                     unsQ      <= funct3_i[2];
                     loadQ     <= !memWrite_i;
`ifdef MEM_TIMEOUT_EN
                     waitCnt   <= '0;
`endif
                     state     <= WAIT;
                  end
               end
            end
            WAIT: begin
               // An ack on the watchdog's last cycle still completes normally.
               if (mem.ack) begin
                  mem.req <= 1'b0;
                  if (loadQ) memData_o <= extractLoad(mem.rdata, laneQ, sizeQ, unsQ);
                  state   <= DONE;
               end
`ifdef MEM_TIMEOUT_EN
               else if (waitCnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                  mem.req <= 1'b0;
                  err_o   <= 1'b1;
                  if (loadQ) memData_o <= 32'hDEADBEEF;
                  state   <= DONE;
               end else begin
                  waitCnt <= waitCnt + CNT_W'(1);
               end
`endif
            end
            default: begin
               // The held instruction is still on the inputs here; ignore it so it is not reissued.
               state <= IDLE;
            end
         endcase
      end
   end

`ifndef MEM_TIMEOUT_EN
   assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
`timescale 1ns/1ps
module tb_mem_access_unit;
   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        memRead_i = 1'b0;
   logic        memWrite_i = 1'b0;
   logic [2:0]  funct3_i = 3'b0;
   logic [31:0] addr_i = 32'b0;
   logic [31:0] wrData_i = 32'b0;
   logic        stall_o;
   logic [31:0] memData_o;
   logic        misalign_o;
   logic        err_o;

   int checks = 0;
   int errors = 0;

   mem_access_unit_if memIf();

   mem_access_unit #(.TIMEOUT_CYC(4)) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .memRead_i (memRead_i),
      .memWrite_i(memWrite_i),
      .funct3_i  (funct3_i),
      .addr_i    (addr_i),
      .wrData_i  (wrData_i),
      .mem       (memIf),
      .stall_o   (stall_o),
      .memData_o (memData_o),
      .misalign_o(misalign_o),
      .err_o     (err_o)
   );

   always #5 clk_i = ~clk_i;

   // Observations of one access, filled by runAccess.
   int          obsStall;
   int          obsReq;
   logic [31:0] obsAddr;
   logic [31:0] obsWdata;
   logic [3:0]  obsBe;
   logic        obsWe;
   logic        obsStable;
   logic        obsTimeout;
   logic [31:0] modelData;

   // Reference model: access size in bytes from funct3.
   function automatic int sizeBytes(input logic [2:0] f3);
      if (f3[1:0] == 2'b00) return 1;
      if (f3[1:0] == 2'b01) return 2;
      return 4;
   endfunction

   function automatic logic [31:0] modelLoad(input logic [31:0] rd, input logic [31:0] a, input logic [2:0] f3);
      int n;
      int off;
      logic [31:0] mask;
      logic [31:0] v;
      n    = sizeBytes(f3);
      off  = int'(a % 4);
      mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
      v    = (rd >> (8 * off)) & mask;
      if (n < 4 && !f3[2] && v[8 * n - 1]) v = v | ~mask;
      return v;
   endfunction

   function automatic logic [3:0] modelBe(input logic isWr, input logic [31:0] a, input logic [2:0] f3);
      int n;
      logic [7:0] wide;
      if (!isWr) return 4'hF;
      n    = sizeBytes(f3);
      wide = 8'(((1 << n) - 1) << int'(a % 4));
      return wide[3:0];
   endfunction

   function automatic logic [31:0] modelWdata(input logic [31:0] wd, input logic [2:0] f3);
      int n;
      logic [31:0] w;
      n = sizeBytes(f3);
      for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % n) +: 8];
      return w;
   endfunction

   // Drive one access, answer ack on the ackN-th request cycle (0 = never), record what the port did.
   task automatic runAccess(input logic isWr, input logic isRd, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] rd, input int ackN);
      @(negedge clk_i);
      memRead_i   = isRd;
      memWrite_i  = isWr;
      funct3_i    = f3;
      addr_i      = a;
      wrData_i    = wd;
      memIf.rdata = rd;
      memIf.ack   = 1'b0;
      obsStall    = 0;
      obsReq      = 0;
      obsStable   = 1'b1;
      obsTimeout  = 1'b1;
      obsAddr     = 32'b0;
      obsWdata    = 32'b0;
      obsBe       = 4'b0;
      obsWe       = 1'b0;
      for (int c = 0; c < 200; c++) begin
         #1;
         if (stall_o) obsStall++;
         if (memIf.req) begin
            if (obsReq == 0) begin
               obsAddr  = memIf.addr;
               obsWdata = memIf.wdata;
               obsBe    = memIf.be;
               obsWe    = memIf.we;
            end else if (memIf.addr !== obsAddr || memIf.wdata !== obsWdata ||
                         memIf.be !== obsBe || memIf.we !== obsWe) begin
               obsStable = 1'b0;
            end
            obsReq++;
            if (obsReq == ackN) memIf.ack = 1'b1;
         end else if (obsReq > 0) begin
            obsTimeout = 1'b0;
            break;
         end
         @(negedge clk_i);
         memIf.ack = 1'b0;
      end
      memIf.ack  = 1'b0;
      memRead_i  = 1'b0;
      memWrite_i = 1'b0;
      @(negedge clk_i);
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      memIf.ack = 1'b0;
      memIf.rdata = 32'b0;
      repeat (2) @(negedge clk_i);
      #1;
      checks++; if (memIf.req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", memIf.req); end
      checks++; if (memIf.we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", memIf.we); end
      checks++; if (memIf.addr !== 32'b0) begin errors++; $display("FAIL reset_addr got %h want 0", memIf.addr); end
      checks++; if (memIf.wdata !== 32'b0) begin errors++; $display("FAIL reset_wdata got %h want 0", memIf.wdata); end
      checks++; if (memIf.be !== 4'b0) begin errors++; $display("FAIL reset_be got %b want 0", memIf.be); end
      checks++; if (memData_o !== 32'b0) begin errors++; $display("FAIL reset_memData got %h want 0", memData_o); end
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err_o); end
      checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall_o); end
      rst_i = 1'b0;
      modelData = 32'b0;
      @(negedge clk_i);
   endtask

   task automatic test_loads();
      runAccess(1'b0, 1'b1, 3'b010, 32'h100, 32'h0, 32'h89AB_CDEF, 1);
      checks++; if (obsTimeout !== 1'b0) begin errors++; $display("FAIL lw_complete got timeout=%b want 0", obsTimeout); end
      checks++; if (obsStall != 2) begin errors++; $display("FAIL lw_stall got %0d want 2", obsStall); end
      checks++; if (memData_o !== 32'h89AB_CDEF) begin errors++; $display("FAIL lw_data got %h want 89abcdef", memData_o); end
      checks++; if (obsAddr !== 32'h100) begin errors++; $display("FAIL lw_addr got %h want 100", obsAddr); end
      checks++; if (obsBe !== 4'b1111) begin errors++; $display("FAIL lw_be got %b want 1111", obsBe); end
      checks++; if (obsWe !== 1'b0) begin errors++; $display("FAIL lw_we got %b want 0", obsWe); end
      runAccess(1'b0, 1'b1, 3'b000, 32'h103, 32'h0, 32'h8011_2233, 1);
      checks++; if (memData_o !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data got %h want ffffff80", memData_o); end
      runAccess(1'b0, 1'b1, 3'b100, 32'h103, 32'h0, 32'h8011_2233, 2);
      checks++; if (memData_o !== 32'h0000_0080) begin errors++; $display("FAIL lbu_data got %h want 00000080", memData_o); end
      runAccess(1'b0, 1'b1, 3'b101, 32'h102, 32'h0, 32'h8011_2233, 1);
      checks++; if (memData_o !== 32'h0000_8011) begin errors++; $display("FAIL lhu_data got %h want 00008011", memData_o); end
      modelData = 32'h0000_8011;
   endtask

   task automatic test_store();
      runAccess(1'b1, 1'b0, 3'b001, 32'h206, 32'h0000_BEEF, 32'h5555_5555, 5);
      checks++; if (obsReq != 5) begin errors++; $display("FAIL sh_req_cycles got %0d want 5", obsReq); end
      checks++; if (obsAddr !== 32'h204) begin errors++; $display("FAIL sh_addr got %h want 204", obsAddr); end
      checks++; if (obsBe !== 4'b1100) begin errors++; $display("FAIL sh_be got %b want 1100", obsBe); end
      checks++; if (obsWdata !== 32'hBEEF_BEEF) begin errors++; $display("FAIL sh_wdata got %h want beefbeef", obsWdata); end
      checks++; if (obsWe !== 1'b1) begin errors++; $display("FAIL sh_we got %b want 1", obsWe); end
      checks++; if (obsStable !== 1'b1) begin errors++; $display("FAIL sh_stable got %b want 1", obsStable); end
      checks++; if (memData_o !== modelData) begin errors++; $display("FAIL sh_memData got %h want %h", memData_o, modelData); end
   endtask

   task automatic test_misalign();
      // Misaligned store: flagged, no traffic, load data untouched.
      @(negedge clk_i);
      memWrite_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h102; wrData_i = 32'h1234_5678;
      #1;
      checks++; if (misalign_o !== 1'b1) begin errors++; $display("FAIL sw_mis_flag got %b want 1", misalign_o); end
      @(negedge clk_i); #1;
      checks++; if (memIf.req !== 1'b0) begin errors++; $display("FAIL sw_mis_req got %b want 0", memIf.req); end
      checks++; if (memData_o !== modelData) begin errors++; $display("FAIL sw_mis_memData got %h want %h", memData_o, modelData); end
      memWrite_i = 1'b0;
      // Misaligned load: flagged, no stall, write-back value zero.
      @(negedge clk_i);
      memRead_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h101;
      #1;
      checks++; if (misalign_o !== 1'b1) begin errors++; $display("FAIL lw_mis_flag got %b want 1", misalign_o); end
      checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL lw_mis_stall got %b want 0", stall_o); end
      @(negedge clk_i); #1;
      checks++; if (memIf.req !== 1'b0) begin errors++; $display("FAIL lw_mis_req got %b want 0", memIf.req); end
      checks++; if (memData_o !== 32'b0) begin errors++; $display("FAIL lw_mis_memData got %h want 0", memData_o); end
      memRead_i = 1'b0;
      #1;
      checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL mis_clear got %b want 0", misalign_o); end
      modelData = 32'b0;
   endtask

   task automatic test_reset_mid_wait();
      runAccess(1'b0, 1'b1, 3'b010, 32'h380, 32'h0, 32'hA5A5_0F0F, 1);
      modelData = 32'hA5A5_0F0F;
      @(negedge clk_i);
      memRead_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h300;
      @(negedge clk_i); #1;
      checks++; if (memIf.req !== 1'b1) begin errors++; $display("FAIL rst_pre_req got %b want 1", memIf.req); end
      rst_i = 1'b1;
      #1;
      checks++; if (memIf.req !== 1'b0) begin errors++; $display("FAIL rst_req_drop got %b want 0", memIf.req); end
      checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL rst_stall_drop got %b want 0", stall_o); end
      memRead_i = 1'b0;
      modelData = 32'b0;
      @(negedge clk_i);
      rst_i = 1'b0;
      memIf.rdata = 32'h1234_5678;
      memIf.ack = 1'b1;
      @(negedge clk_i);
      memIf.ack = 1'b0;
      #1;
      checks++; if (memIf.req !== 1'b0) begin errors++; $display("FAIL stray_ack_req got %b want 0", memIf.req); end
      checks++; if (memData_o !== modelData) begin errors++; $display("FAIL stray_ack_memData got %h want %h", memData_o, modelData); end
      runAccess(1'b0, 1'b1, 3'b010, 32'h300, 32'h0, 32'hCAFE_F00D, 2);
      checks++; if (obsStall != 3) begin errors++; $display("FAIL post_rst_stall got %0d want 3", obsStall); end
      checks++; if (memData_o !== 32'hCAFE_F00D) begin errors++; $display("FAIL post_rst_data got %h want cafef00d", memData_o); end
      modelData = 32'hCAFE_F00D;
   endtask

   task automatic test_back_to_back();
      logic [5:0] stallSeq;
      logic [5:0] reqSeq;
      @(negedge clk_i);
      memRead_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h400;
      memIf.rdata = 32'h0BAD_F00D;
      memIf.ack = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) @(negedge clk_i);
         #1;
         stallSeq[i] = stall_o;
         reqSeq[i]   = memIf.req;
      end
      memRead_i = 1'b0;
      memIf.ack = 1'b0;
      @(negedge clk_i);
      // Held instruction reissues only after the DONE cycle; ack outside WAIT has no effect.
      checks++; if (stallSeq !== 6'b011011) begin errors++; $display("FAIL b2b_stall got %b want 011011", stallSeq); end
      checks++; if (reqSeq !== 6'b010010) begin errors++; $display("FAIL b2b_req got %b want 010010", reqSeq); end
      modelData = modelLoad(32'h0BAD_F00D, 32'h400, 3'b010);
      checks++; if (memData_o !== modelData) begin errors++; $display("FAIL b2b_data got %h want %h", memData_o, modelData); end
   endtask

   task automatic test_random();
      for (int k = 0; k < 40; k++) begin
         logic [2:0]  f3;
         logic [31:0] a, wd, rd;
         logic        isWr, isRd;
         int          ackN, n;
         f3   = 3'($urandom_range(0, 7));
         n    = sizeBytes(f3);
         a    = $urandom & ~(32'(n) - 32'd1);
         isWr = 1'($urandom_range(0, 1));
         isRd = isWr ? 1'($urandom_range(0, 1)) : 1'b1;
         ackN = $urandom_range(1, 4);
         wd   = $urandom;
         rd   = $urandom;
         runAccess(isWr, isRd, f3, a, wd, rd, ackN);
         if (!isWr) modelData = modelLoad(rd, a, f3);
         checks++; if (obsTimeout !== 1'b0) begin errors++; $display("FAIL rnd%0d_complete got timeout=%b want 0", k, obsTimeout); end
         checks++; if (obsStall != ackN + 1) begin errors++; $display("FAIL rnd%0d_stall got %0d want %0d", k, obsStall, ackN + 1); end
         checks++; if (obsReq != ackN) begin errors++; $display("FAIL rnd%0d_req got %0d want %0d", k, obsReq, ackN); end
         checks++; if (obsAddr !== (a & 32'hFFFF_FFFC)) begin errors++; $display("FAIL rnd%0d_addr got %h want %h", k, obsAddr, a & 32'hFFFF_FFFC); end
         checks++; if (obsBe !== modelBe(isWr, a, f3)) begin errors++; $display("FAIL rnd%0d_be got %b want %b", k, obsBe, modelBe(isWr, a, f3)); end
         checks++; if (obsWe !== isWr) begin errors++; $display("FAIL rnd%0d_we got %b want %b", k, obsWe, isWr); end
         checks++; if (obsStable !== 1'b1) begin errors++; $display("FAIL rnd%0d_stable got %b want 1", k, obsStable); end
         checks++; if (memData_o !== modelData) begin errors++; $display("FAIL rnd%0d_data got %h want %h", k, memData_o, modelData); end
         if (isWr) begin
            checks++; if (obsWdata !== modelWdata(wd, f3)) begin errors++; $display("FAIL rnd%0d_wdata got %h want %h", k, obsWdata, modelWdata(wd, f3)); end
         end
      end
`ifndef MEM_TIMEOUT_EN
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_tied got %b want 0", err_o); end
`endif
   endtask

`ifdef MEM_TIMEOUT_EN
   task automatic test_timeout();
      // Ack on the last allowed WAIT cycle completes normally.
      runAccess(1'b0, 1'b1, 3'b010, 32'h600, 32'h0, 32'h1357_9BDF, 4);
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL to_edge_err got %b want 0", err_o); end
      checks++; if (memData_o !== 32'h1357_9BDF) begin errors++; $display("FAIL to_edge_data got %h want 13579bdf", memData_o); end
      runAccess(1'b0, 1'b1, 3'b010, 32'h500, 32'h0, 32'h2468_ACE0, 0);
      checks++; if (obsTimeout !== 1'b0) begin errors++; $display("FAIL to_release got timeout=%b want 0", obsTimeout); end
      checks++; if (obsReq != 4) begin errors++; $display("FAIL to_req_cycles got %0d want 4", obsReq); end
      checks++; if (obsStall != 5) begin errors++; $display("FAIL to_stall got %0d want 5", obsStall); end
      checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL to_err got %b want 1", err_o); end
      checks++; if (memData_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL to_data got %h want deadbeef", memData_o); end
      runAccess(1'b0, 1'b1, 3'b010, 32'h504, 32'h0, 32'h0000_1111, 1);
      checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL to_sticky got %b want 1", err_o); end
      checks++; if (memData_o !== 32'h0000_1111) begin errors++; $display("FAIL to_recover got %h want 00001111", memData_o); end
   endtask
`endif

   initial begin
      memIf.ack = 1'b0;
      memIf.rdata = 32'b0;
      modelData = 32'b0;
      test_reset();
      test_loads();
      test_store();
      test_misalign();
      test_reset_mid_wait();
      test_back_to_back();
      test_random();
`ifdef MEM_TIMEOUT_EN
      test_timeout();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage block between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Turns load/store control from EX/MEM into requests on a variable-latency data-memory port that uses a req/ack handshake.
- Stalls the pipeline until the access completes.
- Produces the size-extracted, sign/zero-extended load value that feeds MEM/WB memData_i.

Parameters:
- TIMEOUT_CYC, 64: ack watchdog limit in cycles. Used only with MEM_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- rst_i  in  1  asynchronous active-high reset.
- memRead_i  in  1  load request from EX/MEM.
- memWrite_i  in  1  store request from EX/MEM.
- funct3_i  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr_i  in  32  byte address (ALU result).
- wrData_i  in  32  store data (rs2).
- mem_req_o  out  1  memory request, held until ack.
- mem_we_o  out  1  1 = write.
- mem_addr_o  out  32  word address, {addr[31:2],2'b00}.
- mem_wdata_o  out  32  lane-replicated store data.
- mem_be_o  out  4  byte enables.
- mem_rdata_i  in  32  read word; valid with ack.
- mem_ack_i  in  1  access complete.
- stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; hold MEM/WB input.
- memData_o  out  32  extracted load data to MEM/WB.
- misalign_o  out  1  misaligned access flag (combinational).
- err_o  out  1  timeout error (MEM_TIMEOUT_EN only; otherwise tied 0).

Behaviour:
- Reset values: state IDLE; mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, mem_be_o=0; memData_o=0; err_o=0.
- Reset is asynchronous and can assert in any state. It drops mem_req_o immediately and the pending access is abandoned.
- access = memRead_i | memWrite_i. A store takes priority if both are high.
- misaligned:
  - H/HU with addr[0]=1.
  - W with addr[1:0]!=0.
  - funct3 011/110/111 is treated as W.
- States:
  - IDLE:
    - access & !misaligned: stall_o=1. Latch mem_* request fields and load lane/sign info; next WAIT.
    - access & misaligned: misalign_o=1, stall_o=0, no memory traffic. memData_o<=0 if load. Stay IDLE.
    - no access: stall_o=0.
  - WAIT:
    - mem_req_o=1. Address, data and enables stay stable.
    - stall_o=1.
    - On mem_ack_i: capture the extracted load into memData_o (loads only; stores leave it unchanged), mem_req_o<=0, next DONE.
  - DONE:
    - stall_o=0 for exactly one cycle; the pipeline advances.
    - Inputs are ignored, so the held instruction is not reissued.
    - Next IDLE.
- Minimum access time: access seen at T0, req high at T1, ack at T1, DONE at T2. Stall is high for 2 cycles.
- mem_ack_i outside WAIT is ignored.
- Store encoding:
  - SB: be=4'b0001<<addr[1:0], wdata={4{wrData_i[7:0]}}.
  - SH: be=4'b0011 or 4'b1100 by addr[1], wdata={2{wrData_i[15:0]}}.
  - SW: be=4'b1111.
  - Loads: be=4'b1111, we=0.
- Load extraction:
  - Byte lane selected by addr[1:0]; halfword by addr[1].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- memData_o holds its value between loads.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYC without ack: mem_req_o<=0, err_o<=1 (sticky until reset), memData_o<=32'hDEADBEEF for loads, next DONE.
  - An ack arriving in the same cycle as the limit wins.
- MEM_TIMEOUT_EN undefined:
  - No counter; WAIT lasts indefinitely.
  - err_o is constant 0.

Test Plan:
- LW at addr 0x100, ack 1 cycle after req, rdata 0x89ABCDEF -> stall high for 2 cycles; memData_o=0x89ABCDEF; mem_addr_o=0x100, be=1111.
- LB at addr 0x103, rdata 0x80112233 -> memData_o=0xFFFFFF80. LBU at the same address -> 0x00000080. LHU at 0x102 -> 0x00008011.
- SH at addr 0x206, wrData 0x0000BEEF, ack after 5 cycles -> req held 5 cycles with mem_addr_o=0x204, be=1100, wdata=0xBEEFBEEF, we=1; memData_o unchanged.
- LW at addr 0x101 -> misalign_o=1, stall_o=0, mem_req_o stays 0, memData_o=0.
- rst_i pulsed mid-WAIT (req high) -> mem_req_o=0 and stall_o=0 before the next clock edge; a later ack is ignored; the next LW completes normally.
- MEM_TIMEOUT_EN, TIMEOUT_CYC=4, LW with no ack -> req drops after 4 WAIT cycles; err_o=1; memData_o=0xDEADBEEF; stall_o releases in DONE.
